// File: rtl/gl_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// gl_cmd_sequencer_pkg
//   Shared definitions for the GL command sequencer: opcode encodings,
//   sequencer state encoding and a helper that identifies the states that
//   wait on a downstream *_done handshake.
// ---------------------------------------------------------------------------
package gl_cmd_sequencer_pkg;

    // GL opcodes as delivered by the command front end
    localparam logic [7:0] OP_BEGIN      = 8'h00;
    localparam logic [7:0] OP_END        = 8'h01;
    localparam logic [7:0] OP_VERTEX     = 8'h02;
    localparam logic [7:0] OP_COLOR      = 8'h03;
    localparam logic [7:0] OP_MATRIXMODE = 8'h04;
    localparam logic [7:0] OP_LOADID     = 8'h05;
    localparam logic [7:0] OP_PUSH       = 8'h06;
    localparam logic [7:0] OP_POP        = 8'h07;
    localparam logic [7:0] OP_MULTMATRIX = 8'h08;
    localparam logic [7:0] OP_LOADMATRIX = 8'h09;
    localparam logic [7:0] OP_VIEWPORT   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_MV_MUL    = 3'd2,
        ST_PJ_MUL    = 3'd3,
        ST_PDIV      = 3'd4,
        ST_FIFO_WR   = 3'd5,
        ST_LOAD_ROWS = 3'd6,
        ST_MM_WAIT   = 3'd7
    } seq_state_t;

    // States in which the done timer runs and a timeout can abort the command
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ST_MV_MUL) || (s == ST_PJ_MUL) ||
               (s == ST_PDIV)   || (s == ST_MM_WAIT);
    endfunction

endpackage

// File: rtl/gl_cmd_sequencer_done_timer.sv
// ---------------------------------------------------------------------------
// gl_cmd_sequencer_done_timer
//   Counts cycles spent waiting for a done handshake.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     clear     force count to zero (start of a new wait)
//     enable    count this cycle (saturates at DONE_TO+1)
//     first     count is zero: this is the cycle of the start pulse
//     timeout   count has exceeded DONE_TO
// ---------------------------------------------------------------------------
module gl_cmd_sequencer_done_timer #(
    parameter int DONE_TO = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic first,
    output logic timeout
);

    localparam int                CNT_W   = $clog2(DONE_TO + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DONE_TO + 1);

    logic [CNT_W-1:0] count;

    // Saturating so a stalled state can never wrap back below the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign first   = (count == '0);
    assign timeout = (count > CNT_W'(DONE_TO));

endmodule

// File: rtl/gl_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// gl_cmd_sequencer
//   Accepts one GL command per valid/ready handshake and sequences the
//   matrix-multiply, perspective-divide, matrix-stack and FIFO units by
//   waiting on their done handshakes. Holds viewport, current colour and
//   matrix-mode state.
//   Ports:
//     clk, rst                       clock / asynchronous active-high reset
//     cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//     cmd_opcode, cmd_imm            GL opcode and immediate (imm[0] = mode)
//     bram_addr_in                   operand base address of the command
//     bram_addr_out, bram_mux_sel    BRAM address and ownership (1 = matrix)
//     bram_rdata                     four words, 1-cycle read latency
//     viewport_x/y/width/height      viewport registers
//     color_out                      current colour, NUM_CH words
//     matrix_mode_out                0 modelview, 1 projection
//     matrix_mul_en/type, mul_done   multiply start pulse / type / done
//     matrix_load_en, matrix_load_id_en, push_en, pop_en   stack pulses
//     pdiv_en, pdiv_done             perspective divide start / done
//     fifo_write_en, fifo_full       vertex FIFO write pulse / back-pressure
//     err_illegal, err_timeout       sticky error flags
// ---------------------------------------------------------------------------
module gl_cmd_sequencer
    import gl_cmd_sequencer_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_CH      = 4,
    parameter int                MAT_ROWS    = 4,
    parameter int                ADDR_STRIDE = 4,
    parameter int                DONE_TO     = 31,
    parameter logic [DATA_W-1:0] VP_W_RST    = 32'h43A00000,
    parameter logic [DATA_W-1:0] VP_H_RST    = 32'h43700000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_opcode,
    input  logic [22:0]              cmd_imm,
    input  logic [ADDR_W-1:0]        bram_addr_in,
    output logic [ADDR_W-1:0]        bram_addr_out,
    output logic                     bram_mux_sel,
    input  logic [4*DATA_W-1:0]      bram_rdata,
    output logic [DATA_W-1:0]        viewport_x,
    output logic [DATA_W-1:0]        viewport_y,
    output logic [DATA_W-1:0]        viewport_width,
    output logic [DATA_W-1:0]        viewport_height,
    output logic [NUM_CH*DATA_W-1:0] color_out,
    output logic                     matrix_mode_out,
    output logic                     matrix_mul_en,
    output logic                     matrix_mul_type,
    input  logic                     mul_done,
    output logic                     matrix_load_en,
    output logic                     matrix_load_id_en,
    output logic                     push_en,
    output logic                     pop_en,
    output logic                     pdiv_en,
    input  logic                     pdiv_done,
    output logic                     fifo_write_en,
    input  logic                     fifo_full,
    output logic                     err_illegal,
    output logic                     err_timeout
);

    localparam int ROW_W = $clog2(MAT_ROWS + 1) + 1;

    seq_state_t       state;
    logic             curr_mode;
    logic             fetch_color;
    logic             fetch_wait;
    logic [ROW_W-1:0] row_cnt;

    logic in_wait;
    logic done_sel;
    logic wait_done;
    logic timer_first;
    logic timer_timeout;
    logic timer_clear;

    // Only imm[0] carries meaning; the rest is reduced so it is visibly consumed
    logic unused_imm;
    assign unused_imm = ^cmd_imm[22:1];

    assign cmd_ready = (state == ST_IDLE);

    // A done seen during the start-pulse cycle belongs to nothing we issued,
    // so the timer's first cycle masks it. Leaving a wait state or honouring
    // a done restarts the count for the next stage.
    always_comb begin
        done_sel = 1'b0;
        case (state)
            ST_MV_MUL, ST_PJ_MUL, ST_MM_WAIT: done_sel = mul_done;
            ST_PDIV:                          done_sel = pdiv_done;
            default:                          done_sel = 1'b0;
        endcase
    end

    assign in_wait     = is_wait_state(state);
    assign wait_done   = in_wait && !timer_first && done_sel;
    assign timer_clear = !in_wait || wait_done;

    gl_cmd_sequencer_done_timer #(
        .DONE_TO (DONE_TO)
    ) u_done_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (in_wait),
        .first   (timer_first),
        .timeout (timer_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            curr_mode         <= 1'b0;
            fetch_color       <= 1'b0;
            fetch_wait        <= 1'b0;
            row_cnt           <= '0;
            bram_addr_out     <= '0;
            bram_mux_sel      <= 1'b0;
            viewport_x        <= '0;
            viewport_y        <= '0;
            viewport_width    <= VP_W_RST;
            viewport_height   <= VP_H_RST;
            color_out         <= '0;
            matrix_mode_out   <= 1'b0;
            matrix_mul_en     <= 1'b0;
            matrix_mul_type   <= 1'b0;
            matrix_load_en    <= 1'b0;
            matrix_load_id_en <= 1'b0;
            push_en           <= 1'b0;
            pop_en            <= 1'b0;
            pdiv_en           <= 1'b0;
            fifo_write_en     <= 1'b0;
            err_illegal       <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            // Every enable is a single-cycle pulse unless re-asserted below
            matrix_mul_en     <= 1'b0;
            matrix_load_en    <= 1'b0;
            matrix_load_id_en <= 1'b0;
            push_en           <= 1'b0;
            pop_en            <= 1'b0;
            pdiv_en           <= 1'b0;
            fifo_write_en     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_opcode)
                            OP_BEGIN, OP_END: ;
                            OP_MATRIXMODE: curr_mode <= cmd_imm[0];
                            OP_LOADID: begin
                                matrix_mode_out   <= curr_mode;
                                matrix_load_id_en <= 1'b1;
                            end
                            OP_PUSH: begin
                                matrix_mode_out <= curr_mode;
                                push_en         <= 1'b1;
                            end
                            OP_POP: begin
                                matrix_mode_out <= curr_mode;
                                pop_en          <= 1'b1;
                            end
                            OP_COLOR, OP_VIEWPORT: begin
                                bram_addr_out <= bram_addr_in;
                                fetch_color   <= (cmd_opcode == OP_COLOR);
                                fetch_wait    <= 1'b1;
                                state         <= ST_FETCH;
                            end
                            OP_VERTEX: begin
                                bram_mux_sel    <= 1'b0;
                                bram_addr_out   <= bram_addr_in;
                                matrix_mode_out <= 1'b0;
                                matrix_mul_type <= 1'b0;
                                matrix_mul_en   <= 1'b1;
                                state           <= ST_MV_MUL;
                            end
                            OP_MULTMATRIX: begin
                                bram_mux_sel    <= 1'b1;
                                matrix_mode_out <= curr_mode;
                                matrix_mul_type <= 1'b1;
                                matrix_mul_en   <= 1'b1;
                                state           <= ST_MM_WAIT;
                            end
                            OP_LOADMATRIX: begin
                                matrix_mode_out <= curr_mode;
                                bram_addr_out   <= bram_addr_in;
                                matrix_load_en  <= 1'b1;
                                row_cnt         <= '0;
                                state           <= (MAT_ROWS > 1) ? ST_LOAD_ROWS : ST_IDLE;
                            end
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end

                // One cycle for the BRAM to see the address, one to return data
                ST_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        if (fetch_color) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                color_out[k*DATA_W +: DATA_W] <= bram_rdata[k*DATA_W +: DATA_W];
                            end
                        end else begin
                            viewport_x      <= bram_rdata[0*DATA_W +: DATA_W];
                            viewport_y      <= bram_rdata[1*DATA_W +: DATA_W];
                            viewport_width  <= bram_rdata[2*DATA_W +: DATA_W];
                            viewport_height <= bram_rdata[3*DATA_W +: DATA_W];
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_MV_MUL: begin
                    if (wait_done) begin
                        matrix_mode_out <= 1'b1;
                        matrix_mul_en   <= 1'b1;
                        state           <= ST_PJ_MUL;
                    end else if (timer_timeout) begin
                        err_timeout  <= 1'b1;
                        bram_mux_sel <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                ST_PJ_MUL: begin
                    if (wait_done) begin
                        pdiv_en <= 1'b1;
                        state   <= ST_PDIV;
                    end else if (timer_timeout) begin
                        err_timeout  <= 1'b1;
                        bram_mux_sel <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                ST_PDIV: begin
                    if (wait_done) begin
                        state <= ST_FIFO_WR;
                    end else if (timer_timeout) begin
                        err_timeout  <= 1'b1;
                        bram_mux_sel <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                // Back-pressure is legitimate here, so no timeout applies
                ST_FIFO_WR: begin
                    if (!fifo_full) begin
                        fifo_write_en <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                // Row 0 went out on accept; each cycle here issues one more row
                ST_LOAD_ROWS: begin
                    bram_addr_out <= bram_addr_out + ADDR_W'(ADDR_STRIDE);
                    if (row_cnt == ROW_W'(MAT_ROWS - 2)) begin
                        state <= ST_IDLE;
                    end else begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                end

                ST_MM_WAIT: begin
                    if (wait_done) begin
                        bram_mux_sel <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (timer_timeout) begin
                        err_timeout  <= 1'b1;
                        bram_mux_sel <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gl_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gl_cmd_sequencer
//   Directed bench for gl_cmd_sequencer with a small registered BRAM model.
// ---------------------------------------------------------------------------
module tb_gl_cmd_sequencer;
    import gl_cmd_sequencer_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int NUM_CH  = 4;
    localparam int DONE_TO = 31;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [7:0]               cmd_opcode = 8'h00;
    logic [22:0]              cmd_imm = '0;
    logic [ADDR_W-1:0]        bram_addr_in = '0;
    logic [ADDR_W-1:0]        bram_addr_out;
    logic                     bram_mux_sel;
    logic [4*DATA_W-1:0]      bram_rdata;
    logic [DATA_W-1:0]        viewport_x, viewport_y, viewport_width, viewport_height;
    logic [NUM_CH*DATA_W-1:0] color_out;
    logic                     matrix_mode_out, matrix_mul_en, matrix_mul_type;
    logic                     mul_done = 1'b0;
    logic                     matrix_load_en, matrix_load_id_en, push_en, pop_en;
    logic                     pdiv_en;
    logic                     pdiv_done = 1'b0;
    logic                     fifo_write_en;
    logic                     fifo_full = 1'b0;
    logic                     err_illegal, err_timeout;

    int check_count = 0;
    int error_count = 0;

    gl_cmd_sequencer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_CH      (NUM_CH),
        .MAT_ROWS    (4),
        .ADDR_STRIDE (4),
        .DONE_TO     (DONE_TO),
        .VP_W_RST    (32'h43A00000),
        .VP_H_RST    (32'h43700000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_opcode        (cmd_opcode),
        .cmd_imm           (cmd_imm),
        .bram_addr_in      (bram_addr_in),
        .bram_addr_out     (bram_addr_out),
        .bram_mux_sel      (bram_mux_sel),
        .bram_rdata        (bram_rdata),
        .viewport_x        (viewport_x),
        .viewport_y        (viewport_y),
        .viewport_width    (viewport_width),
        .viewport_height   (viewport_height),
        .color_out         (color_out),
        .matrix_mode_out   (matrix_mode_out),
        .matrix_mul_en     (matrix_mul_en),
        .matrix_mul_type   (matrix_mul_type),
        .mul_done          (mul_done),
        .matrix_load_en    (matrix_load_en),
        .matrix_load_id_en (matrix_load_id_en),
        .push_en           (push_en),
        .pop_en            (pop_en),
        .pdiv_en           (pdiv_en),
        .pdiv_done         (pdiv_done),
        .fifo_write_en     (fifo_write_en),
        .fifo_full         (fifo_full),
        .err_illegal       (err_illegal),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    // Registered BRAM: data for an address appears one cycle after it is driven
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_rdata <= '0;
        end else begin
            case (bram_addr_out)
                32'h40:  bram_rdata <= {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
                32'h80:  bram_rdata <= {32'h3F800000, 32'h3F400000, 32'h3F000000, 32'h3E800000};
                default: bram_rdata <= {4{32'hDEADBEEF}};
            endcase
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single cycle; returns in the cycle after accept
    task automatic applyStimulus(input logic [7:0] op, input logic [22:0] imm,
                                 input logic [ADDR_W-1:0] addr);
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_imm      = imm;
        bram_addr_in = addr;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int mul_pulses, last_mul, pdiv_cycle, writes, write_cycle, cyc;
        logic mode_at3, mode_at4, ready_at15, ready_at16;

        // ---------------- reset state ----------------
        repeat (3) step();
        checkOutput("rst_ready", cmd_ready, 1'b1);
        checkOutput("rst_vp_w", viewport_width, 32'h43A00000);
        checkOutput("rst_vp_h", viewport_height, 32'h43700000);
        checkOutput("rst_vp_x", viewport_x, 32'h0);
        checkOutput("rst_color", color_out, 128'h0);
        rst = 1'b0;
        step();

        // ---------------- BEGIN stays idle ----------------
        applyStimulus(OP_BEGIN, 23'd0, 32'h0);
        checkOutput("begin_ready", cmd_ready, 1'b1);

        // ---------------- VIEWPORT ----------------
        applyStimulus(OP_VIEWPORT, 23'd0, 32'h40);
        checkOutput("vp_addr", bram_addr_out, 32'h40);
        checkOutput("vp_busy", cmd_ready, 1'b0);
        step();
        checkOutput("vp_x_early", viewport_x, 32'h0);
        step();
        checkOutput("vp_x", viewport_x, 32'h3F800000);
        checkOutput("vp_y", viewport_y, 32'h40000000);
        checkOutput("vp_w", viewport_width, 32'h40400000);
        checkOutput("vp_h", viewport_height, 32'h40800000);
        checkOutput("vp_ready", cmd_ready, 1'b1);

        // ---------------- COLOR ----------------
        applyStimulus(OP_COLOR, 23'd0, 32'h80);
        step();
        step();
        checkOutput("color", color_out,
                    {32'h3F800000, 32'h3F400000, 32'h3F000000, 32'h3E800000});

        // ---------------- LOADMATRIX ----------------
        applyStimulus(OP_LOADMATRIX, 23'd0, 32'h100);
        checkOutput("lm_addr0", bram_addr_out, 32'h100);
        checkOutput("lm_load_en", matrix_load_en, 1'b1);
        checkOutput("lm_mode", matrix_mode_out, 1'b0);
        step();
        checkOutput("lm_addr1", bram_addr_out, 32'h104);
        checkOutput("lm_load_en_off", matrix_load_en, 1'b0);
        step();
        checkOutput("lm_addr2", bram_addr_out, 32'h108);
        checkOutput("lm_busy", cmd_ready, 1'b0);
        step();
        checkOutput("lm_addr3", bram_addr_out, 32'h10C);
        checkOutput("lm_ready", cmd_ready, 1'b1);

        // ---------------- VERTEX full pipeline ----------------
        applyStimulus(OP_VERTEX, 23'd0, 32'h200);
        checkOutput("vx_mul_en0", matrix_mul_en, 1'b1);
        checkOutput("vx_mode0", matrix_mode_out, 1'b0);
        checkOutput("vx_type", matrix_mul_type, 1'b0);
        checkOutput("vx_addr", bram_addr_out, 32'h200);
        mul_pulses = 0; last_mul = -1; pdiv_cycle = -1; writes = 0; write_cycle = -1;
        mode_at3 = 1'bx; mode_at4 = 1'bx; ready_at15 = 1'bx; ready_at16 = 1'bx;
        for (int c = 0; c < 20; c++) begin
            mul_done  = (c == 3) || (c == 7);
            pdiv_done = (c == 10);
            fifo_full = (c >= 11) && (c <= 14);
            step();
            cyc = c + 1;
            if (matrix_mul_en) begin mul_pulses++; last_mul = cyc; end
            if (pdiv_en) pdiv_cycle = cyc;
            if (fifo_write_en) begin writes++; write_cycle = cyc; end
            if (cyc == 3) mode_at3 = matrix_mode_out;
            if (cyc == 4) mode_at4 = matrix_mode_out;
            if (cyc == 15) ready_at15 = cmd_ready;
            if (cyc == 16) ready_at16 = cmd_ready;
        end
        mul_done = 1'b0; pdiv_done = 1'b0; fifo_full = 1'b0;
        checkOutput("vx_mode_mv", mode_at3, 1'b0);
        checkOutput("vx_mode_pj", mode_at4, 1'b1);
        checkOutput("vx_mul_pulses", mul_pulses, 1);
        checkOutput("vx_pj_mul_cycle", last_mul, 4);
        checkOutput("vx_pdiv_cycle", pdiv_cycle, 8);
        checkOutput("vx_writes", writes, 1);
        checkOutput("vx_write_cycle", write_cycle, 16);
        checkOutput("vx_busy_full", ready_at15, 1'b0);
        checkOutput("vx_ready", ready_at16, 1'b1);

        // ---------------- MATRIXMODE 1, MULTMATRIX with early done ----------------
        applyStimulus(OP_MATRIXMODE, 23'd1, 32'h0);
        applyStimulus(OP_MULTMATRIX, 23'd0, 32'h0);
        checkOutput("mm_mux", bram_mux_sel, 1'b1);
        checkOutput("mm_type", matrix_mul_type, 1'b1);
        checkOutput("mm_mode", matrix_mode_out, 1'b1);
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        checkOutput("mm_early_done_ignored", cmd_ready, 1'b0);
        step();
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        checkOutput("mm_done_mux", bram_mux_sel, 1'b0);
        checkOutput("mm_done_ready", cmd_ready, 1'b1);
        checkOutput("mm_no_timeout", err_timeout, 1'b0);

        // ---------------- MULTMATRIX timeout ----------------
        applyStimulus(OP_MULTMATRIX, 23'd0, 32'h0);
        repeat (DONE_TO + 1) step();
        checkOutput("to_not_yet", err_timeout, 1'b0);
        checkOutput("to_mux_held", bram_mux_sel, 1'b1);
        step();
        checkOutput("to_flag", err_timeout, 1'b1);
        checkOutput("to_mux_released", bram_mux_sel, 1'b0);
        checkOutput("to_ready", cmd_ready, 1'b1);

        // ---------------- illegal opcode then PUSH ----------------
        applyStimulus(8'hFF, 23'd0, 32'h0);
        checkOutput("ill_flag", err_illegal, 1'b1);
        checkOutput("ill_ready", cmd_ready, 1'b1);
        applyStimulus(OP_PUSH, 23'd0, 32'h0);
        checkOutput("push_en", push_en, 1'b1);
        checkOutput("push_mode", matrix_mode_out, 1'b1);
        step();
        checkOutput("push_single", push_en, 1'b0);

        // ---------------- POP / LOADID in modelview ----------------
        applyStimulus(OP_MATRIXMODE, 23'd0, 32'h0);
        applyStimulus(OP_POP, 23'd0, 32'h0);
        checkOutput("pop_en", pop_en, 1'b1);
        checkOutput("pop_mode", matrix_mode_out, 1'b0);
        applyStimulus(OP_LOADID, 23'd0, 32'h0);
        checkOutput("loadid_en", matrix_load_id_en, 1'b1);
        checkOutput("loadid_pop_off", pop_en, 1'b0);

        // ---------------- reset during PJ_MUL ----------------
        applyStimulus(OP_VERTEX, 23'd0, 32'h300);
        step();
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        step();
        checkOutput("rm_in_pj", matrix_mode_out, 1'b1);
        rst = 1'b1;
        #2;
        checkOutput("rm_mode", matrix_mode_out, 1'b0);
        checkOutput("rm_addr", bram_addr_out, 32'h0);
        checkOutput("rm_err_t", err_timeout, 1'b0);
        checkOutput("rm_err_i", err_illegal, 1'b0);
        checkOutput("rm_vp_w", viewport_width, 32'h43A00000);
        rst = 1'b0;
        step();
        checkOutput("rm_ready", cmd_ready, 1'b1);
        checkOutput("rm_no_pulse", {matrix_mul_en, pdiv_en, fifo_write_en}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
